// File: rtl/axi_pe_isolate_ctrl_pkg.sv
// rtl/axi_pe_isolate_ctrl_pkg.sv - shared AXI types, FSM states and response codes for PE isolation
package axi_pe_isolate_ctrl_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 1024;
  localparam int unsigned DefIdWidth   = 4;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_ISOLATED,
    ST_RELEASE
  } iso_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } err_wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } err_rd_state_e;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic [DefAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [DefDataWidth-1:0]   data;
    logic [DefDataWidth/8-1:0] strb;
    logic                      last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic [DefDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_pe_isolate_ctrl_err_slv.sv
// rtl/axi_pe_isolate_ctrl_err_slv.sv - local SLVERR responder, one write and one read in flight
module axi_pe_isolate_ctrl_err_slv
  import axi_pe_isolate_ctrl_pkg::*;
#(
  parameter int unsigned IdWidth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic               aw_valid,
  input  logic [IdWidth-1:0] aw_id,
  output logic               aw_ready,
  input  logic               w_valid,
  input  logic               w_last,
  output logic               w_ready,
  output logic               b_valid,
  output logic [IdWidth-1:0] b_id,
  input  logic               b_ready,
  input  logic               ar_valid,
  input  logic [IdWidth-1:0] ar_id,
  input  logic [7:0]         ar_len,
  output logic               ar_ready,
  output logic               r_valid,
  output logic [IdWidth-1:0] r_id,
  output logic               r_last,
  input  logic               r_ready,
  output logic               idle,
  output logic               b_done,
  output logic               r_done
);

  err_wr_state_e      wr_state_q, wr_state_d;
  err_rd_state_e      rd_state_q, rd_state_d;
  logic [IdWidth-1:0] b_id_q;
  logic [IdWidth-1:0] r_id_q;
  logic [7:0]         r_len_q;
  logic [7:0]         r_cnt_q;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    b_done     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        aw_ready = accept;
        if (aw_valid && accept) wr_state_d = WR_DATA;
      end
      WR_DATA: begin
        w_ready = 1'b1;
        if (w_valid && w_last) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        b_valid = 1'b1;
        if (b_ready) begin
          b_done     = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    ar_ready   = 1'b0;
    r_valid    = 1'b0;
    r_last     = 1'b0;
    r_done     = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        ar_ready = accept;
        if (ar_valid && accept) rd_state_d = RD_DATA;
      end
      RD_DATA: begin
        r_valid = 1'b1;
        r_last  = (r_cnt_q == r_len_q);
        if (r_ready && r_last) begin
          r_done     = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      b_id_q     <= '0;
      r_id_q     <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      if (aw_valid && aw_ready) b_id_q <= aw_id;
      if (ar_valid && ar_ready) begin
        r_id_q  <= ar_id;
        r_len_q <= ar_len;
        r_cnt_q <= '0;
      end else if (r_valid && r_ready) begin
        r_cnt_q <= r_cnt_q + 8'd1;
      end
    end
  end

  assign b_id = b_id_q;
  assign r_id = r_id_q;
  assign idle = (wr_state_q == WR_IDLE) && (rd_state_q == RD_IDLE);

endmodule

// File: rtl/axi_pe_isolate_ctrl.sv
// rtl/axi_pe_isolate_ctrl.sv - per-PE AXI traffic gate: drain, isolate with SLVERR, release
module axi_pe_isolate_ctrl
  import axi_pe_isolate_ctrl_pkg::*;
#(
  parameter int unsigned AxiAddrWidth   = DefAddrWidth,
  parameter int unsigned AxiDataWidth   = DefDataWidth,
  parameter int unsigned AxiIdWidth     = DefIdWidth,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         req_t          = axi_req_t,
  parameter type         resp_t         = axi_resp_t,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  req_t                slv_req_i,
  output resp_t               slv_resp_o,
  output req_t                mst_req_o,
  input  resp_t               mst_resp_i,
  input  logic                isolate_i,
  output logic                isolated_o,
  output logic [CntWidth-1:0] wr_out_o,
  output logic [CntWidth-1:0] rd_out_o,
  output logic [15:0]         err_cnt_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  iso_state_e          state_q, state_d;
  logic [CntWidth-1:0] wr_out_q, wr_out_d;
  logic [CntWidth-1:0] rd_out_q, rd_out_d;
  logic [CntWidth-1:0] w_pend_q, w_pend_d;
  logic [15:0]         err_cnt_q;
  logic [16:0]         err_sum;

  req_t  mst_req;
  resp_t slv_resp;

  logic aw_full, ar_full;
  logic aw_fwd, w_last_fwd, b_fwd, ar_fwd, r_last_fwd;

  logic                  err_accept, err_idle, err_b_done, err_r_done;
  logic                  e_aw_ready, e_w_ready, e_b_valid, e_ar_ready;
  logic                  e_r_valid, e_r_last;
  logic [AxiIdWidth-1:0] e_b_id, e_r_id;

  assign aw_full    = (wr_out_q == MaxCnt);
  assign ar_full    = (rd_out_q == MaxCnt);
  assign err_accept = (state_q == ST_ISOLATED);

  axi_pe_isolate_ctrl_err_slv #(
    .IdWidth (AxiIdWidth)
  ) u_err_slv (
    .clk      (clk_i),
    .rst      (rst_i),
    .accept   (err_accept),
    .aw_valid (slv_req_i.aw_valid),
    .aw_id    (slv_req_i.aw.id),
    .aw_ready (e_aw_ready),
    .w_valid  (slv_req_i.w_valid),
    .w_last   (slv_req_i.w.last),
    .w_ready  (e_w_ready),
    .b_valid  (e_b_valid),
    .b_id     (e_b_id),
    .b_ready  (slv_req_i.b_ready),
    .ar_valid (slv_req_i.ar_valid),
    .ar_id    (slv_req_i.ar.id),
    .ar_len   (slv_req_i.ar.len),
    .ar_ready (e_ar_ready),
    .r_valid  (e_r_valid),
    .r_id     (e_r_id),
    .r_last   (e_r_last),
    .r_ready  (slv_req_i.r_ready),
    .idle     (err_idle),
    .b_done   (err_b_done),
    .r_done   (err_r_done)
  );

  // Pass-through by default; each state only overrides the handshakes it blocks.
  always_comb begin
    mst_req  = slv_req_i;
    slv_resp = mst_resp_i;
    case (state_q)
      ST_RUN: begin
        if (aw_full) begin
          mst_req.aw_valid  = 1'b0;
          slv_resp.aw_ready = 1'b0;
        end
        if (ar_full) begin
          mst_req.ar_valid  = 1'b0;
          slv_resp.ar_ready = 1'b0;
        end
      end
      ST_DRAIN: begin
        mst_req.aw_valid  = 1'b0;
        mst_req.ar_valid  = 1'b0;
        slv_resp.aw_ready = 1'b0;
        slv_resp.ar_ready = 1'b0;
      end
      default: begin
        mst_req.aw_valid  = 1'b0;
        mst_req.w_valid   = 1'b0;
        mst_req.ar_valid  = 1'b0;
        mst_req.b_ready   = 1'b0;
        mst_req.r_ready   = 1'b0;
        slv_resp          = '0;
        slv_resp.aw_ready = e_aw_ready;
        slv_resp.w_ready  = e_w_ready;
        slv_resp.b_valid  = e_b_valid;
        slv_resp.b.id     = e_b_id;
        slv_resp.b.resp   = RESP_SLVERR;
        slv_resp.ar_ready = e_ar_ready;
        slv_resp.r_valid  = e_r_valid;
        slv_resp.r.id     = e_r_id;
        slv_resp.r.resp   = RESP_SLVERR;
        slv_resp.r.last   = e_r_last;
      end
    endcase
  end

  assign aw_fwd     = mst_req.aw_valid && mst_resp_i.aw_ready;
  assign w_last_fwd = mst_req.w_valid && mst_resp_i.w_ready && mst_req.w.last;
  assign b_fwd      = mst_resp_i.b_valid && mst_req.b_ready;
  assign ar_fwd     = mst_req.ar_valid && mst_resp_i.ar_ready;
  assign r_last_fwd = mst_resp_i.r_valid && mst_req.r_ready && mst_resp_i.r.last;

  assign wr_out_d = wr_out_q + CntWidth'(aw_fwd) - CntWidth'(b_fwd);
  assign rd_out_d = rd_out_q + CntWidth'(ar_fwd) - CntWidth'(r_last_fwd);
  assign w_pend_d = w_pend_q + CntWidth'(aw_fwd) - CntWidth'(w_last_fwd);
  assign err_sum  = {1'b0, err_cnt_q} + 17'(err_b_done) + 17'(err_r_done);

  // DRAIN looks at next-cycle counts so isolation lands right after the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (isolate_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!isolate_i) state_d = ST_RUN;
        else if ((wr_out_d == '0) && (rd_out_d == '0) && (w_pend_d == '0)) state_d = ST_ISOLATED;
      end
      ST_ISOLATED: if (!isolate_i) state_d = ST_RELEASE;
      ST_RELEASE:  if (err_idle) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      wr_out_q  <= '0;
      rd_out_q  <= '0;
      w_pend_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_out_q  <= wr_out_d;
      rd_out_q  <= rd_out_d;
      w_pend_q  <= w_pend_d;
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign mst_req_o  = mst_req;
  assign slv_resp_o = slv_resp;
  assign isolated_o = (state_q == ST_ISOLATED);
  assign wr_out_o   = wr_out_q;
  assign rd_out_o   = rd_out_q;
  assign err_cnt_o  = err_cnt_q;

  assert property (@(posedge clk_i) disable iff (rst_i)
    ($bits(slv_req_i.aw.addr) == AxiAddrWidth) && ($bits(slv_req_i.w.data) == AxiDataWidth));
  assert property (@(posedge clk_i) disable iff (rst_i) !(b_fwd && (wr_out_q == '0)));
  assert property (@(posedge clk_i) disable iff (rst_i) !(r_last_fwd && (rd_out_q == '0)));
  assert property (@(posedge clk_i) disable iff (rst_i) !(w_last_fwd && !aw_fwd && (w_pend_q == '0)));

endmodule

// File: tb/tb_axi_pe_isolate_ctrl.sv
// tb/tb_axi_pe_isolate_ctrl.sv - directed self-checking bench for axi_pe_isolate_ctrl
module tb_axi_pe_isolate_ctrl;
  import axi_pe_isolate_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        isolate;
  axi_req_t    slv_req, mst_req;
  axi_resp_t   slv_resp, mst_resp;
  logic        isolated;
  logic [3:0]  wr_out, rd_out;
  logic [15:0] err_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  axi_pe_isolate_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .isolate_i  (isolate),
    .isolated_o (isolated),
    .wr_out_o   (wr_out),
    .rd_out_o   (rd_out),
    .err_cnt_o  (err_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [63:0] r_beat(input logic last, input logic [3:0] id);
    return 64'({slv_resp.r_valid, slv_resp.r.last, slv_resp.r.resp, slv_resp.r.id,
                slv_resp.r.data == '0}) ^ 64'({1'b1, last, 2'b10, id, 1'b1});
  endfunction

  initial begin
    rst = 1'b1; isolate = 1'b0; slv_req = '0; mst_resp = '0;
    #12;
    check_eq("rst_isolated", 64'(isolated), 64'd0);
    check_eq("rst_wr_out", 64'(wr_out), 64'd0);
    check_eq("rst_rd_out", 64'(rd_out), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("rst_slv_resp_zero", 64'(slv_resp == '0), 64'd1);
    check_eq("rst_mst_req_zero", 64'(mst_req == '0), 64'd1);
    @(negedge clk); rst = 1'b0;
    tick();

    // RUN: write burst len=3
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd1; slv_req.aw.addr = 32'h100; slv_req.aw.len = 8'd3;
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1; mst_resp.ar_ready = 1'b1;
    settle();
    check_eq("run_aw_valid", 64'(mst_req.aw_valid), 64'd1);
    check_eq("run_aw_addr", 64'(mst_req.aw.addr), 64'h100);
    check_eq("run_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
    tick(); slv_req.aw_valid = 1'b0;
    check_eq("run_wr_out_1", 64'(wr_out), 64'd1);
    for (int i = 0; i < 4; i++) begin
      slv_req.w_valid = 1'b1; slv_req.w.data = '0; slv_req.w.data[7:0] = 8'hA0 + 8'(i);
      slv_req.w.last = (i == 3);
      settle();
      check_eq("run_w_data", 64'(mst_req.w.data[63:0]), 64'hA0 + 64'(i));
      tick();
    end
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd1; slv_req.b_ready = 1'b1;
    settle();
    check_eq("run_b_pass", 64'({slv_resp.b_valid, slv_resp.b.id}), 64'h11);
    tick(); mst_resp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
    check_eq("run_wr_out_0", 64'(wr_out), 64'd0);

    // RUN: read burst len=3
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd2; slv_req.ar.len = 8'd3;
    settle();
    check_eq("run_ar_pass", 64'({mst_req.ar_valid, mst_req.ar.id}), 64'h12);
    tick(); slv_req.ar_valid = 1'b0;
    check_eq("run_rd_out_1", 64'(rd_out), 64'd1);
    slv_req.r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mst_resp.r_valid = 1'b1; mst_resp.r.id = 4'd2; mst_resp.r.data = '0;
      mst_resp.r.data[7:0] = 8'hB0 + 8'(i); mst_resp.r.last = (i == 3);
      settle();
      check_eq("run_r_data", 64'(slv_resp.r.data[63:0]), 64'hB0 + 64'(i));
      tick();
    end
    mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0;
    check_eq("run_rd_out_0", 64'(rd_out), 64'd0);
    check_eq("run_err_cnt", 64'(err_cnt), 64'd0);

    // Drain: two writes and one read outstanding
    for (int i = 0; i < 2; i++) begin
      slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'(i + 1); slv_req.aw.len = 8'd0;
      slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
      tick();
    end
    slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd3; slv_req.ar.len = 8'd0;
    tick(); slv_req.ar_valid = 1'b0;
    check_eq("drain_pre_out", 64'({wr_out, rd_out}), 64'h21);
    isolate = 1'b1;
    tick();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd5; slv_req.aw.len = 8'd1;
    settle();
    check_eq("drain_aw_gated", 64'({mst_req.aw_valid, slv_resp.aw_ready}), 64'd0);
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd1; slv_req.b_ready = 1'b1;
    tick(); mst_resp.b.id = 4'd2;
    tick(); mst_resp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
    check_eq("drain_wr_out_0", 64'(wr_out), 64'd0);
    check_eq("drain_not_iso_rd", 64'(isolated), 64'd0);
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 4'd3; mst_resp.r.last = 1'b1;
    settle();
    check_eq("drain_not_iso_last", 64'(isolated), 64'd0);
    tick(); mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0;
    settle();
    check_eq("drain_isolated", 64'(isolated), 64'd1);
    check_eq("drain_rd_out_0", 64'(rd_out), 64'd0);
    check_eq("iso_aw_local", 64'({slv_resp.aw_ready, mst_req.aw_valid}), 64'b10);

    // Isolated error write id=5 len=1
    tick(); slv_req.aw_valid = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b0;
    settle();
    check_eq("iso_w_sink", 64'({slv_resp.w_ready, mst_req.w_valid}), 64'b10);
    tick(); slv_req.w.last = 1'b1;
    tick(); slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    settle();
    check_eq("iso_b", 64'({slv_resp.b_valid, slv_resp.b.id, slv_resp.b.resp}), 64'({1'b1, 4'd5, 2'b10}));
    slv_req.b_ready = 1'b1;
    tick(); slv_req.b_ready = 1'b0;
    settle();
    check_eq("iso_b_done", 64'(slv_resp.b_valid), 64'd0);
    check_eq("iso_err_cnt_1", 64'(err_cnt), 64'd1);
    check_eq("iso_w_hold_no_aw", 64'(slv_resp.w_ready), 64'd0);

    // Isolated error read id=3 len=3
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd3; slv_req.ar.len = 8'd3;
    settle();
    check_eq("iso_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
    tick(); slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("iso_r_beat", r_beat(i == 3, 4'd3), 64'd0);
      tick();
    end
    settle();
    check_eq("iso_r_done", 64'(slv_resp.r_valid), 64'd0);
    check_eq("iso_err_cnt_2", 64'(err_cnt), 64'd2);

    // Release during an active error read
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd6; slv_req.ar.len = 8'd3;
    tick(); slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) isolate = 1'b0;
      settle();
      check_eq("rel_r_beat", r_beat(i == 3, 4'd6), 64'd0);
      if (i >= 2) check_eq("rel_not_isolated", 64'(isolated), 64'd0);
      tick();
    end
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd7; slv_req.ar.len = 8'd0;
    settle();
    check_eq("rel_err_cnt_3", 64'(err_cnt), 64'd3);
    check_eq("rel_ar_blocked", 64'({mst_req.ar_valid, slv_resp.ar_ready}), 64'd0);
    tick();
    check_eq("rel_ar_to_pe", 64'({mst_req.ar_valid, mst_req.ar.id}), 64'h17);
    tick(); slv_req.ar_valid = 1'b0;
    check_eq("rel_rd_out_1", 64'(rd_out), 64'd1);
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 4'd7; mst_resp.r.last = 1'b1;
    tick(); mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0;
    check_eq("rel_rd_out_0", 64'(rd_out), 64'd0);

    // Outstanding limit: PE withholds B
    for (int i = 0; i < 8; i++) begin
      slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'(i); slv_req.aw.len = 8'd0;
      slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
      tick();
    end
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0; slv_req.aw.id = 4'd9;
    settle();
    check_eq("lim_wr_out_8", 64'(wr_out), 64'd8);
    check_eq("lim_aw9_stall", 64'({mst_req.aw_valid, slv_resp.aw_ready}), 64'd0);
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd0; slv_req.b_ready = 1'b1;
    settle();
    check_eq("lim_aw9_stall_b", 64'(mst_req.aw_valid), 64'd0);
    tick(); mst_resp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
    settle();
    check_eq("lim_aw9_pass", 64'({mst_req.aw_valid, slv_resp.aw_ready}), 64'b11);
    check_eq("lim_wr_out_7", 64'(wr_out), 64'd7);
    tick(); slv_req.aw_valid = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
    tick(); slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    check_eq("lim_wr_out_8b", 64'(wr_out), 64'd8);

    // Async reset in the middle of DRAIN
    isolate = 1'b1;
    tick();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd2;
    settle();
    check_eq("ar_drain_gated", 64'(mst_req.aw_valid), 64'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_wr_out", 64'(wr_out), 64'd0);
    check_eq("arst_rd_out", 64'(rd_out), 64'd0);
    check_eq("arst_isolated", 64'(isolated), 64'd0);
    check_eq("arst_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("arst_run_pass", 64'(mst_req.aw_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
